hazard_stall_controller: RTL and testbench

//  Pipeline sequencer for the five-stage MIPS CPU. It works alongside the EX-stage forwarding unit.
//  It detects hazards that forwarding cannot resolve (load-use, ID-stage branch operands) and

---
 rtl/hazard_stall_controller.sv | 119 +++++++++++
 tb/tb_hazard_stall_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard detection and stall/flush sequencing for a five-stage MIPS pipeline, including
// the mult/div start/busy/done sequencer with HI/LO interlock and a saturating stall counter.
module hazard_stall_controller #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic             ID_EX_MultDiv,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_RegisterRd,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic             ID_IsBranch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_HiLoUse,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic [CNT_W-1:0] StallCycles
);

  // state   | meaning
  // RUN     | no mult/div in flight; a mult/div entering EX launches the unit
  // MD_BUSY | mult/div in flight; HI/LO readers interlocked until the done cycle
  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic md_start, md_done, busy;
  logic load_use, br_ex, br_mem, hilo, stall;

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ID_EX_MultDiv) begin
          md_start = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q == 6'd0) begin
          md_done = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign busy = (state_q == MD_BUSY);

  always_comb begin
    load_use = ID_EX_MemRead &
               src_match(ID_EX_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt);
    br_ex    = ID_IsBranch & ID_EX_RegWrite &
               src_match(ID_EX_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt);
    br_mem   = ID_IsBranch & EX_MEM_MemRead &
               src_match(EX_MEM_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_UsesRt);
    // HI/LO become valid at the end of the done cycle, so the reader is released in it
    hilo     = ID_HiLoUse & busy & ~md_done;
    stall    = rst_n & (load_use | br_ex | br_mem | hilo);
  end

  // While reset is held every output is forced, independent of the inputs
  always_comb begin
    PCWrite      = rst_n & ~stall;
    IF_ID_Write  = rst_n & ~stall;
    ID_EX_Bubble = ~rst_n | stall;
    IF_ID_Flush  = rst_n & (ID_BranchTaken | ID_Jump) & ~stall;
    MD_Start     = rst_n & md_start;
    MD_Busy      = rst_n & busy;
    MD_Done      = rst_n & md_done;
    StallCycles  = stall_cnt_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 6'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_hazard_stall_controller;

  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ID_EX_MemRead = 0, ID_EX_RegWrite = 0, ID_EX_MultDiv = 0, EX_MEM_MemRead = 0;
  logic [4:0] ID_EX_RegisterRd = 0, EX_MEM_RegisterRd = 0, IF_ID_RegisterRs = 0, IF_ID_RegisterRt = 0;
  logic ID_UsesRt = 0, ID_IsBranch = 0, ID_BranchTaken = 0, ID_Jump = 0, ID_HiLoUse = 0;
  logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Start, MD_Busy, MD_Done;
  logic [CW-1:0] StallCycles;

  hazard_stall_controller #(.DIV_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_RegisterRd(ID_EX_RegisterRd), .ID_EX_MultDiv(ID_EX_MultDiv),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
    .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .ID_Jump(ID_Jump), .ID_HiLoUse(ID_HiLoUse),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
    .MD_Done(MD_Done), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the mult/div op is tracked by its launch timestamp, not a counter
  int   cyc = 0;
  int   m_start = 0;
  int   m_stalls = 0;
  logic m_active = 1'b0;
  logic m_done, e_stall, e_pcw, e_bub, e_flush, e_start, e_busy, e_done;

  function automatic logic mt(input logic [4:0] r);
    return (r != 0) && ((r == IF_ID_RegisterRs) || (ID_UsesRt && (r == IF_ID_RegisterRt)));
  endfunction

  always_comb begin
    m_done  = m_active && ((cyc - m_start) == D);
    e_stall = rst_n && ((ID_EX_MemRead && mt(ID_EX_RegisterRd)) ||
                        (ID_IsBranch && ID_EX_RegWrite && mt(ID_EX_RegisterRd)) ||
                        (ID_IsBranch && EX_MEM_MemRead && mt(EX_MEM_RegisterRd)) ||
                        (ID_HiLoUse && m_active && !m_done));
    e_pcw   = rst_n && !e_stall;
    e_bub   = !rst_n || e_stall;
    e_flush = rst_n && (ID_BranchTaken || ID_Jump) && !e_stall;
    e_start = rst_n && !m_active && ID_EX_MultDiv;
    e_busy  = rst_n && m_active;
    e_done  = rst_n && m_done;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_stalls <= 0;
    end else begin
      if (m_done) m_active <= 1'b0;
      else if (!m_active && ID_EX_MultDiv) begin
        m_active <= 1'b1;
        m_start  <= cyc;
      end
      if (e_stall && (m_stalls < SMAX)) m_stalls <= m_stalls + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCWrite", PCWrite, e_pcw);
      chk("IF_ID_Write", IF_ID_Write, e_pcw);
      chk("ID_EX_Bubble", ID_EX_Bubble, e_bub);
      chk("IF_ID_Flush", IF_ID_Flush, e_flush);
      chk("MD_Start", MD_Start, e_start);
      chk("MD_Busy", MD_Busy, e_busy);
      chk("MD_Done", MD_Done, e_done);
      chk("StallCycles", StallCycles, m_stalls);
    end
  end

  task automatic clr();
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_MultDiv = 0; EX_MEM_MemRead = 0;
    ID_EX_RegisterRd = 0; EX_MEM_RegisterRd = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    ID_UsesRt = 0; ID_IsBranch = 0; ID_BranchTaken = 0; ID_Jump = 0; ID_HiLoUse = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    next();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset PCWrite", PCWrite, 0);
    chk("reset Bubble", ID_EX_Bubble, 1);
    chk("reset StallCycles", StallCycles, 0);
    next();
    rst_n = 1'b1;

    // load-use on rs
    ID_EX_MemRead = 1; ID_EX_RegisterRd = 2; IF_ID_RegisterRs = 2;
    @(negedge clk);
    chk("lu PCWrite", PCWrite, 0);
    chk("lu IF_ID_Write", IF_ID_Write, 0);
    chk("lu Bubble", ID_EX_Bubble, 1);
    next();
    clr();
    @(negedge clk);
    chk("lu after PCWrite", PCWrite, 1);
    chk("lu after Bubble", ID_EX_Bubble, 0);
    chk("lu StallCycles", StallCycles, 1);
    next();

    // r0 never matches; rt ignored when not used
    ID_EX_MemRead = 1; ID_EX_RegisterRd = 0; IF_ID_RegisterRs = 0;
    @(negedge clk);
    chk("r0 PCWrite", PCWrite, 1);
    next();
    ID_EX_RegisterRd = 7; IF_ID_RegisterRt = 7; IF_ID_RegisterRs = 3; ID_UsesRt = 0;
    @(negedge clk);
    chk("rt unused PCWrite", PCWrite, 1);
    chk("no-stall StallCycles", StallCycles, 1);
    next();

    // mult/div sequencing with mflo waiting in ID
    do_reset();
    ID_EX_MultDiv = 1;
    @(negedge clk);
    chk("md MD_Start", MD_Start, 1);
    chk("md Busy@0", MD_Busy, 0);
    for (int k = 1; k <= 4; k++) begin
      next();
      ID_EX_MultDiv = 0; ID_HiLoUse = 1;
      @(negedge clk);
      chk("md Busy", MD_Busy, 1);
      chk("md Done", MD_Done, (k == 4) ? 1 : 0);
      chk("md hilo PCWrite", PCWrite, (k == 4) ? 1 : 0);
    end
    next();
    ID_HiLoUse = 0;
    @(negedge clk);
    chk("md StallCycles", StallCycles, 3);
    chk("md Busy after", MD_Busy, 0);
    next();

    // branch operand from ID_EX, then resolved next cycle
    do_reset();
    ID_IsBranch = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 5; IF_ID_RegisterRs = 5; ID_BranchTaken = 1;
    @(negedge clk);
    chk("br stall PCWrite", PCWrite, 0);
    chk("br stall Flush", IF_ID_Flush, 0);
    next();
    ID_EX_RegisterRd = 9;
    @(negedge clk);
    chk("br Flush", IF_ID_Flush, 1);
    chk("br PCWrite", PCWrite, 1);
    next();

    // asynchronous reset in the middle of a mult/div op
    do_reset();
    ID_EX_MultDiv = 1;
    next();
    ID_EX_MultDiv = 0;
    next();
    @(negedge clk);
    #2;
    ID_EX_MultDiv = 1; ID_Jump = 1;
    rst_n = 1'b0;
    #1;
    chk("async Busy", MD_Busy, 0);
    chk("async PCWrite", PCWrite, 0);
    chk("async IF_ID_Write", IF_ID_Write, 0);
    chk("async Bubble", ID_EX_Bubble, 1);
    chk("async MD_Start", MD_Start, 0);
    chk("async Flush", IF_ID_Flush, 0);
    next();
    clr();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort MD_Done", MD_Done, 0);
      next();
    end
    chk("abort StallCycles", StallCycles, 0);

    // independent instruction during MD_BUSY, then counter saturation
    do_reset();
    ID_EX_MultDiv = 1;
    next();
    ID_EX_MultDiv = 0; IF_ID_RegisterRs = 9; IF_ID_RegisterRt = 10; ID_UsesRt = 1;
    @(negedge clk);
    chk("indep Busy", MD_Busy, 1);
    chk("indep PCWrite", PCWrite, 1);
    repeat (6) next();
    clr();
    ID_EX_MemRead = 1; ID_EX_RegisterRd = 2; IF_ID_RegisterRs = 2;
    repeat (20) next();
    clr();
    @(negedge clk);
    chk("sat StallCycles", StallCycles, 15);
    next();

    // randomized traffic with occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ID_EX_MemRead     = ($urandom_range(0, 3) == 0);
      ID_EX_RegWrite    = ($urandom_range(0, 1) == 0);
      ID_EX_RegisterRd  = 5'($urandom_range(0, 3));
      ID_EX_MultDiv     = ($urandom_range(0, 9) == 0);
      EX_MEM_MemRead    = ($urandom_range(0, 3) == 0);
      EX_MEM_RegisterRd = 5'($urandom_range(0, 3));
      IF_ID_RegisterRs  = 5'($urandom_range(0, 3));
      IF_ID_RegisterRt  = 5'($urandom_range(0, 3));
      ID_UsesRt         = ($urandom_range(0, 1) == 0);
      ID_IsBranch       = ($urandom_range(0, 2) == 0);
      ID_BranchTaken    = ($urandom_range(0, 2) == 0);
      ID_Jump           = ($urandom_range(0, 5) == 0);
      ID_HiLoUse        = ($urandom_range(0, 2) == 0);
      rst_n             = ($urandom_range(0, 99) != 0);
      next();
    end
    rst_n = 1'b1;
    clr();
    next();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
